// File: rtl/capture_pkg.sv
// Shared types and SRAM timing constants for the capture sequencer and its SRAM access port.
package capture_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StPost,
        StDone,
        StRdWait
    } seq_state_e;

    localparam int unsigned SRAM_W_CYCLES = 2;
    localparam int unsigned SRAM_R_CYCLES = 2;

endpackage

// File: rtl/capture_sram_sequencer_if.sv
// External sample SRAM pin bundle; the sequencer side is master, the memory side is slave.
interface capture_sram_sequencer_if #(
    parameter int unsigned SRAM_DW = 16,
    parameter int unsigned SRAM_AW = 16
);

    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] dq_out;
    logic               dq_oe;
    logic [SRAM_DW-1:0] dq_in;
    logic               ce_n;
    logic               oe_n;
    logic               we_n;

    modport master (
        output addr,
        output dq_out,
        output dq_oe,
        output ce_n,
        output oe_n,
        output we_n,
        input  dq_in
    );

    modport slave (
        input  addr,
        input  dq_out,
        input  dq_oe,
        input  ce_n,
        input  oe_n,
        input  we_n,
        output dq_in
    );

endinterface

// File: rtl/sram_access_port.sv
// Drives the SRAM pins for one multi-cycle read or write at a time; every strobe is a flop.
module sram_access_port
    import capture_pkg::*;
#(
    parameter int unsigned SRAM_DW = 16,
    parameter int unsigned SRAM_AW = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                start,
    input  logic                start_we,
    input  logic [SRAM_AW-1:0]  start_addr,
    input  logic [SRAM_DW-1:0]  start_wdata,
    output logic                ready,
    output logic                ack,
    output logic                ack_we,
    capture_sram_sequencer_if.master sram
);

    localparam logic [1:0] WLast = 2'(SRAM_W_CYCLES - 1);
    localparam logic [1:0] RLast = 2'(SRAM_R_CYCLES - 1);

    logic               busy_q, busy_d;
    logic               we_q, we_d;
    logic [1:0]         cyc_q, cyc_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_DW-1:0] wdata_q, wdata_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               dq_oe_q, dq_oe_d;

    assign ack    = busy_q && (cyc_q == (we_q ? WLast : RLast));
    assign ack_we = we_q;
    // A new operation may start in the last cycle of the current one (back-to-back writes).
    assign ready  = !busy_q || ack;

    always_comb begin
        busy_d  = busy_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (flush) begin
            busy_d = 1'b0;
            cyc_d  = 2'd0;
        end else if (start && ready) begin
            busy_d = 1'b1;
            cyc_d  = 2'd0;
            we_d   = start_we;
            addr_d = start_addr;
            if (start_we) begin
                wdata_d = start_wdata;
            end
        end else if (ack) begin
            busy_d = 1'b0;
            cyc_d  = 2'd0;
        end else if (busy_q) begin
            cyc_d = cyc_q + 2'd1;
        end
        // Strobes are decoded from the next state so the flops hold the pin values directly.
        ce_n_d  = !busy_d;
        oe_n_d  = !(busy_d && !we_d);
        dq_oe_d = busy_d && we_d;
        we_n_d  = !(busy_d && we_d && (cyc_d == WLast));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            cyc_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign sram.addr   = addr_q;
    assign sram.dq_out = wdata_q;
    assign sram.dq_oe  = dq_oe_q;
    assign sram.ce_n   = ce_n_q;
    assign sram.oe_n   = oe_n_q;
    assign sram.we_n   = we_n_q;

endmodule

// File: rtl/capture_sram_sequencer.sv
// One capture run over the sample SRAM: arm, circular pre-trigger fill, post-trigger count,
// then CPU-paced oldest-first readback. All SRAM traffic goes through one access port.
module capture_sram_sequencer
    import capture_pkg::*;
#(
    parameter int unsigned SRAM_DW      = 16,
    parameter int unsigned SRAM_AW      = 16,
    parameter int unsigned SAMPLE_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    trigger,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic [SRAM_AW-1:0]      post_count,
    input  logic                    rd_req,
    output logic [SRAM_DW-1:0]      rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [SRAM_AW-1:0]      trig_addr,
    capture_sram_sequencer_if.master sram
);

    localparam logic [SRAM_AW:0] Depth = {1'b1, {SRAM_AW{1'b0}}};

    seq_state_e state_q, state_d;

    logic [SRAM_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic                    wrapped_q, wrapped_d;
    logic                    overflow_q;
    logic [SRAM_AW-1:0]      post_left_q;
    logic [SRAM_AW-1:0]      trig_addr_q;
    logic [SRAM_AW-1:0]      rd_ptr_q;
    logic [SRAM_AW:0]        rd_remaining_q;
    logic [SRAM_DW-1:0]      rd_data_q;
    logic                    rd_valid_q;
    logic                    rd_last_q;
    logic                    hold_valid_q;
    logic [SAMPLE_WIDTH-1:0] hold_data_q;
    logic                    hold_trig_q;

    logic               active, capturing, drain, hold_free, accept, drop;
    logic               wr_ack, rd_ack, arm_ok, rd_issue;
    logic [SRAM_AW-1:0] issue_addr;
    logic               port_ready, port_ack, port_ack_we, port_start, port_we;
    logic [SRAM_AW-1:0] port_addr;
    logic [SRAM_DW-1:0] port_wdata;

    always_comb begin
        active     = (state_q == StPre) || (state_q == StPost);
        // Once the post-trigger quota is met, further samples are ignored rather than dropped.
        capturing  = (state_q == StPre) || ((state_q == StPost) && (post_left_q != '0));
        drain      = active && hold_valid_q && port_ready && !abort;
        hold_free  = !hold_valid_q || drain;
        accept     = sample_valid && capturing && hold_free && !abort;
        drop       = sample_valid && capturing && !hold_free && !abort;
        wr_ack     = port_ack && port_ack_we && !abort;
        rd_ack     = port_ack && !port_ack_we && !abort && (state_q == StRdWait);
        arm_ok     = arm && !abort && ((state_q == StIdle) || (state_q == StDone));
        rd_issue   = (state_q == StDone) && rd_req && (rd_remaining_q != '0) && !arm && !abort;
        // A write issued while the previous one completes lands one address further on.
        issue_addr = wr_ack ? wr_ptr_q + SRAM_AW'(1) : wr_ptr_q;
        port_start = drain || rd_issue;
        port_we    = drain;
        port_addr  = drain ? issue_addr : rd_ptr_q;
        port_wdata = SRAM_DW'(hold_data_q);

        wr_ptr_d  = wr_ptr_q;
        wrapped_d = wrapped_q;
        if (arm_ok) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
        end else if (wr_ack) begin
            wr_ptr_d = wr_ptr_q + SRAM_AW'(1);
            if (&wr_ptr_q) begin
                wrapped_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:   if (arm) state_d = StPre;
                StPre:    if (accept && trigger) state_d = StPost;
                StPost: begin
                    if ((post_left_q == '0) && !hold_valid_q && port_ready) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (arm) begin
                        state_d = StPre;
                    end else if (rd_issue) begin
                        state_d = StRdWait;
                    end
                end
                StRdWait: if (rd_ack) state_d = StDone;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            wrapped_q      <= 1'b0;
            overflow_q     <= 1'b0;
            post_left_q    <= '0;
            trig_addr_q    <= '0;
            rd_ptr_q       <= '0;
            rd_remaining_q <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            hold_valid_q   <= 1'b0;
            hold_data_q    <= '0;
            hold_trig_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wrapped_q  <= wrapped_d;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;

            if (abort) begin
                hold_valid_q <= 1'b0;
            end else if (accept) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= sample_data;
                hold_trig_q  <= (state_q == StPre) && trigger;
            end else if (drain) begin
                hold_valid_q <= 1'b0;
            end

            if (drain && hold_trig_q) begin
                trig_addr_q <= issue_addr;
            end

            if (arm_ok) begin
                overflow_q     <= 1'b0;
                post_left_q    <= post_count;
                rd_remaining_q <= '0;
            end else begin
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                if ((state_q == StPost) && accept) begin
                    post_left_q <= post_left_q - SRAM_AW'(1);
                end
            end

            if ((state_q == StPost) && (state_d == StDone)) begin
                rd_ptr_q       <= wrapped_d ? wr_ptr_d : '0;
                rd_remaining_q <= wrapped_d ? Depth : {1'b0, wr_ptr_d};
            end

            if (rd_ack) begin
                rd_data_q      <= sram.dq_in;
                rd_valid_q     <= 1'b1;
                rd_last_q      <= (rd_remaining_q == (SRAM_AW + 1)'(1));
                rd_ptr_q       <= rd_ptr_q + SRAM_AW'(1);
                rd_remaining_q <= rd_remaining_q - (SRAM_AW + 1)'(1);
            end
        end
    end

    sram_access_port #(
        .SRAM_DW (SRAM_DW),
        .SRAM_AW (SRAM_AW)
    ) u_port (
        .clock       (clock),
        .reset       (reset),
        .flush       (abort),
        .start       (port_start),
        .start_we    (port_we),
        .start_addr  (port_addr),
        .start_wdata (port_wdata),
        .ready       (port_ready),
        .ack         (port_ack),
        .ack_we      (port_ack_we),
        .sram        (sram)
    );

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q == StPre) || (state_q == StPost) || (state_q == StRdWait);
    assign done      = (state_q == StDone);
    assign overflow  = overflow_q;
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_capture_sram_sequencer.sv
// Directed bench for capture_sram_sequencer with a small behavioural SRAM on the pin bundle.
module tb_capture_sram_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned SW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trigger = 1'b0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample_data = '0;
    logic [AW-1:0] post_count = '0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW-1:0] trig_addr;

    logic [DW-1:0] mem [16];
    int checks = 0;
    int failures = 0;

    capture_sram_sequencer_if #(.SRAM_DW(DW), .SRAM_AW(AW)) sram_bus ();

    capture_sram_sequencer #(
        .SRAM_DW      (DW),
        .SRAM_AW      (AW),
        .SAMPLE_WIDTH (SW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .abort        (abort),
        .trigger      (trigger),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .post_count   (post_count),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .trig_addr    (trig_addr),
        .sram         (sram_bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!sram_bus.ce_n && !sram_bus.we_n) begin
            mem[sram_bus.addr] <= sram_bus.dq_out;
        end
    end

    assign sram_bus.dq_in = (!sram_bus.ce_n && !sram_bus.oe_n) ? mem[sram_bus.addr] : 16'hdead;

    // Driving data while the SRAM drives the bus would be contention.
    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            assert ((sram_bus.dq_oe & ~sram_bus.oe_n) === 1'b0) else begin
                failures++;
                $error("FAIL bus_contention: observed=1 expected=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_arm(input logic [AW-1:0] pc);
        post_count = pc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send_sample(input logic [SW-1:0] d, input logic trig);
        sample_valid = 1'b1;
        sample_data  = d;
        trigger      = trig;
        tick();
        sample_valid = 1'b0;
        trigger      = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // lat = negedges after the rd_req cycle at which rd_valid was seen, 0 if never.
    task automatic do_read(output int lat, output logic [DW-1:0] d, output logic last);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        lat  = 0;
        d    = '0;
        last = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (lat == 0 && rd_valid === 1'b1) begin
                lat  = k;
                d    = rd_data;
                last = rd_last;
            end
            tick();
        end
    endtask

    task automatic check_reset_values(input string p);
        check({p, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({p, "_rd_last"}, 32'(rd_last), 32'd0);
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_done"}, 32'(done), 32'd0);
        check({p, "_overflow"}, 32'(overflow), 32'd0);
        check({p, "_trig_addr"}, 32'(trig_addr), 32'd0);
        check({p, "_rd_data"}, 32'(rd_data), 32'd0);
        check({p, "_addr"}, 32'(sram_bus.addr), 32'd0);
        check({p, "_dq_out"}, 32'(sram_bus.dq_out), 32'd0);
        check({p, "_dq_oe"}, 32'(sram_bus.dq_oe), 32'd0);
        check({p, "_ce_n"}, 32'(sram_bus.ce_n), 32'd1);
        check({p, "_oe_n"}, 32'(sram_bus.oe_n), 32'd1);
        check({p, "_we_n"}, 32'(sram_bus.we_n), 32'd1);
    endtask

    initial begin
        int            lat;
        logic [DW-1:0] d;
        logic          last;
        int            n;
        logic          saw_rd;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_values("rst");

        // Test 1: no wrap, trigger on 0x15, three post-trigger samples.
        pulse_arm(4'd3);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send_sample(8'(8'h10 + i), (i == 5));
        end
        wait_done("t1_done");
        check("t1_trig_addr", 32'(trig_addr), 32'd5);
        check("t1_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin
            do_read(lat, d, last);
            check("t1_latency", 32'(lat), 32'd3);
            check("t1_data", 32'(d), 32'(16'h10 + i));
            check("t1_last", 32'(last), 32'(i == 8));
        end

        // Test 2: 20 samples into a 16-deep buffer.
        pulse_arm(4'd1);
        for (int i = 0; i < 20; i++) begin
            send_sample(8'(i), (i == 18));
        end
        wait_done("t2_done");
        check("t2_trig_addr", 32'(trig_addr), 32'd2);
        check("t2_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_read(lat, d, last);
            check("t2_data", 32'(d), 32'(i + 4));
            check("t2_last", 32'(last), 32'(i == 15));
        end

        // Test 3: continuous sample_valid overruns the holding register.
        pulse_arm(4'd0);
        sample_valid = 1'b1;
        sample_data  = 8'h55;
        repeat (6) tick();
        sample_valid = 1'b0;
        check("t3_overflow_set", 32'(overflow), 32'd1);
        check("t3_busy_pre", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_idle", 32'(busy), 32'd0);
        check("t3_overflow_held", 32'(overflow), 32'd1);
        pulse_arm(4'd0);
        check("t3_overflow_cleared", 32'(overflow), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Test 4: abort during W2 of the trigger-sample write in POST.
        pulse_arm(4'd5);
        send_sample(8'hc3, 1'b1);
        n = 0;
        while (sram_bus.we_n !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check("t4_w2_seen", 32'(sram_bus.we_n), 32'd0);
        check("t4_busy_post", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_we_n", 32'(sram_bus.we_n), 32'd1);
        check("t4_ce_n", 32'(sram_bus.ce_n), 32'd1);
        check("t4_dq_oe", 32'(sram_bus.dq_oe), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_trig_addr", 32'(trig_addr), 32'd0);
        do_read(lat, d, last);
        check("t4_rd_ignored", 32'(lat), 32'd0);

        // Test 5: post_count = 0, trigger on the first sample.
        pulse_arm(4'd0);
        send_sample(8'ha5, 1'b1);
        wait_done("t5_done");
        do_read(lat, d, last);
        check("t5_latency", 32'(lat), 32'd3);
        check("t5_data", 32'(d), 32'h00a5);
        check("t5_last", 32'(last), 32'd1);
        do_read(lat, d, last);
        check("t5_extra_rd", 32'(lat), 32'd0);

        // Test 6: arm beats rd_req in DONE; reset during RDWAIT.
        pulse_arm(4'd0);
        send_sample(8'h3c, 1'b1);
        wait_done("t6_done_a");
        post_count = 4'd0;
        arm    = 1'b1;
        rd_req = 1'b1;
        tick();
        arm    = 1'b0;
        rd_req = 1'b0;
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_done_low", 32'(done), 32'd0);
        saw_rd = 1'b0;
        repeat (4) begin
            if (rd_valid === 1'b1 || sram_bus.oe_n === 1'b0) saw_rd = 1'b1;
            tick();
        end
        check("t6_no_read", 32'(saw_rd), 32'd0);
        send_sample(8'h5a, 1'b1);
        wait_done("t6_done_b");
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t6_rdwait_busy", 32'(busy), 32'd1);
        check("t6_rdwait_oe_n", 32'(sram_bus.oe_n), 32'd0);
        reset = 1'b1;
        tick();
        check_reset_values("t6_rst");
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
